key_input_ctrl: RTL and testbench

Key input stage sitting between the four raw board push-buttons (Keys pins) and the KabIO register/interrupt fabric, clocked in the IO clock domain. Synchronises and debounces each key, detects press/release edges, latches them as pending events, and raises a level interrupt request with an ID/acknowledge handshake toward the external interrupt controller path. Exposes a small 4-word register file for state, pending, mask and edge configuration.

---
 rtl/key_input_pkg.sv | 32 +++
 rtl/key_debouncer.sv | 72 +++++++
 rtl/key_input_ctrl.sv | 161 ++++++++++++++++
 tb/tb_key_input_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_input_pkg.sv
// Shared definitions for the key input stage: register map, CONFIG bit
// positions, CONFIG reset value and the interrupt priority helper.
package key_input_pkg;

    // Register word addresses
    localparam logic [1:0] ADDR_STATE   = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_CONFIG  = 2'd3;

    // CONFIG bit positions
    localparam int CFG_PRESS   = 0;
    localparam int CFG_RELEASE = 1;

    // Press events enabled, release events disabled out of reset
    localparam logic [1:0] CFG_RESET = 2'b01;

    // Index of the lowest set bit; returns 0 for an all-zero vector, callers
    // qualify with a separate "any set" test.
    function automatic logic [1:0] lowest_set(input logic [3:0] vec);
        logic [1:0] idx;
        casez (vec)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key: two-flop synchroniser on the raw active-low pin, stability
// counter and accepted (debounced) level, plus one-cycle edge pulses that
// coincide with the cycle the accepted level changes.
module key_debouncer
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_WIDTH       = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic stable,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    logic                 sync1_r;
    logic                 sync2_r;
    logic                 level_s;
    logic                 stable_r;
    logic                 press_r;
    logic                 release_r;
    logic [CNT_WIDTH-1:0] count_r;

    // Bring the asynchronous pin into the clock domain; resets to "released"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // Pressed-high view of the synchronised pin
    assign level_s = ~sync2_r;

    // Accept a new level only after it has been seen for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= CNT_ZERO;
            stable_r  <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else if (level_s == stable_r) begin
            count_r   <= CNT_ZERO;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else if (count_r == CNT_LAST) begin
            count_r   <= CNT_ZERO;
            stable_r  <= level_s;
            press_r   <= level_s;
            release_r <= ~level_s;
        end else begin
            count_r   <= count_r + CNT_ONE;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end
    end

    assign stable        = stable_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;

endmodule

// File: rtl/key_input_ctrl.sv
// Key input stage: per-key debouncers, pending event latch, mask/config
// registers, registered read port and a level interrupt request with
// ID/acknowledge handshake.
module key_input_ctrl
    import key_input_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_WIDTH       = 15
) (
    input  logic                IO_Clock,
    input  logic                IO_Reset,
    input  logic [NUM_KEYS-1:0] Keys,
    input  logic                RdEn,
    input  logic                WrEn,
    input  logic [1:0]          Address,
    input  logic [31:0]         WrData,
    output logic [31:0]         RdData,
    output logic                IntReq,
    output logic [1:0]          IntId,
    input  logic                IntAck,
    output logic [NUM_KEYS-1:0] KeyState
);

    localparam logic [NUM_KEYS-1:0] KEYS_ZERO = {NUM_KEYS{1'b0}};

    logic [NUM_KEYS-1:0] stable_s;
    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] release_s;
    logic [NUM_KEYS-1:0] event_s;
    logic [NUM_KEYS-1:0] w1c_s;
    logic [NUM_KEYS-1:0] ack_clr_s;
    logic [NUM_KEYS-1:0] pending_next_s;
    logic [3:0]          req_vec_s;
    logic [31:0]         rd_mux_s;
    logic                unused_wr_s;

    logic [NUM_KEYS-1:0] pending_r;
    logic [NUM_KEYS-1:0] mask_r;
    logic [1:0]          cfg_r;
    logic                int_req_r;
    logic [1:0]          int_id_r;
    logic [31:0]         rd_data_r;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_debouncer (
            .clk           (IO_Clock),
            .rst_n         (IO_Reset),
            .key_n         (Keys[k]),
            .stable        (stable_s[k]),
            .press_pulse   (press_s[k]),
            .release_pulse (release_s[k])
        );
    end

    // Write data bits above the widest register field are never stored
    assign unused_wr_s = ^WrData[31:NUM_KEYS];

    // Next PENDING: enabled edge events set, W1C write and acknowledge clear;
    // a set wins over a clear of the same bit.
    always_comb begin
        event_s   = (press_s   & {NUM_KEYS{cfg_r[CFG_PRESS]}})
                  | (release_s & {NUM_KEYS{cfg_r[CFG_RELEASE]}});
        w1c_s     = KEYS_ZERO;
        ack_clr_s = KEYS_ZERO;
        if (WrEn && (Address == ADDR_PENDING)) begin
            w1c_s = WrData[NUM_KEYS-1:0];
        end else begin
            w1c_s = KEYS_ZERO;
        end
        if (IntAck && int_req_r) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                ack_clr_s[k] = (int_id_r == 2'(k));
            end
        end else begin
            ack_clr_s = KEYS_ZERO;
        end
        pending_next_s = (pending_r & ~(w1c_s | ack_clr_s)) | event_s;
    end

    // Requesting keys, widened to the fixed 4-bit priority encoder input
    always_comb begin
        req_vec_s                 = 4'b0000;
        req_vec_s[NUM_KEYS-1:0]   = pending_r & mask_r;
    end

    // Read mux, zero-extended; unused bits read 0
    always_comb begin
        rd_mux_s = 32'd0;
        case (Address)
            ADDR_STATE:   rd_mux_s[NUM_KEYS-1:0] = stable_s;
            ADDR_PENDING: rd_mux_s[NUM_KEYS-1:0] = pending_r;
            ADDR_MASK:    rd_mux_s[NUM_KEYS-1:0] = mask_r;
            ADDR_CONFIG:  rd_mux_s[1:0]          = cfg_r;
            default:      rd_mux_s               = 32'd0;
        endcase
    end

    // Pending event latch
    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            pending_r <= KEYS_ZERO;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // MASK and CONFIG registers; STATE is read-only and ignores writes
    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            mask_r <= KEYS_ZERO;
            cfg_r  <= CFG_RESET;
        end else if (WrEn) begin
            case (Address)
                ADDR_MASK:   mask_r <= WrData[NUM_KEYS-1:0];
                ADDR_CONFIG: cfg_r  <= WrData[1:0];
                default: begin
                    mask_r <= mask_r;
                    cfg_r  <= cfg_r;
                end
            endcase
        end else begin
            mask_r <= mask_r;
            cfg_r  <= cfg_r;
        end
    end

    // Interrupt request and lowest-index ID; ID holds when nothing requests
    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            int_req_r <= 1'b0;
            int_id_r  <= 2'd0;
        end else if (|req_vec_s) begin
            int_req_r <= 1'b1;
            int_id_r  <= lowest_set(req_vec_s);
        end else begin
            int_req_r <= 1'b0;
            int_id_r  <= int_id_r;
        end
    end

    // Registered read data; sampled from pre-write state, held when idle
    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            rd_data_r <= 32'd0;
        end else if (RdEn) begin
            rd_data_r <= rd_mux_s;
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign RdData   = rd_data_r;
    assign IntReq   = int_req_r;
    assign IntId    = int_id_r;
    assign KeyState = stable_s;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Self-checking bench for key_input_ctrl (4 keys, 8-cycle debounce).
// A behavioural model tracks the expected outputs every cycle; directed
// literal checks pin the model at the key points of each scenario.
module tb_key_input_ctrl;

    localparam int DEB = 8;

    logic        IO_Clock;
    logic        IO_Reset;
    logic [3:0]  Keys;
    logic        RdEn;
    logic        WrEn;
    logic [1:0]  Address;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        IntReq;
    logic [1:0]  IntId;
    logic        IntAck;
    logic [3:0]  KeyState;

    int n_cmp  = 0;
    int n_fail = 0;

    key_input_ctrl #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_WIDTH       (4)
    ) dut (
        .IO_Clock (IO_Clock),
        .IO_Reset (IO_Reset),
        .Keys     (Keys),
        .RdEn     (RdEn),
        .WrEn     (WrEn),
        .Address  (Address),
        .WrData   (WrData),
        .RdData   (RdData),
        .IntReq   (IntReq),
        .IntId    (IntId),
        .IntAck   (IntAck),
        .KeyState (KeyState)
    );

    initial IO_Clock = 1'b0;
    always #5 IO_Clock = ~IO_Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]  m_p1, m_p2;          // pressed-level pin seen 1 and 2 cycles ago
    logic [7:0]  m_hist [4];          // last DEB synchronised samples per key
    logic [3:0]  m_stable, m_press, m_rel;
    logic [3:0]  m_pend, m_mask;
    logic [1:0]  m_cfg;
    logic        m_req;
    logic [1:0]  m_id;
    logic [31:0] m_rd;

    task automatic m_reset();
        m_p1 = 4'h0; m_p2 = 4'h0;
        for (int k = 0; k < 4; k++) m_hist[k] = 8'h00;
        m_stable = 4'h0; m_press = 4'h0; m_rel = 4'h0;
        m_pend = 4'h0; m_mask = 4'h0; m_cfg = 2'b01;
        m_req = 1'b0; m_id = 2'd0; m_rd = 32'd0;
    endtask

    task automatic m_step();
        logic [3:0]  clr, evt, rq, stab_n, press_n, rel_n, pend_n;
        logic [31:0] rd_n;
        logic        req_n;
        logic [1:0]  id_n;
        logic [7:0]  h;
        rd_n = m_rd;
        if (RdEn) begin
            case (Address)
                2'd0:    rd_n = {28'd0, m_stable};
                2'd1:    rd_n = {28'd0, m_pend};
                2'd2:    rd_n = {28'd0, m_mask};
                default: rd_n = {30'd0, m_cfg};
            endcase
        end
        evt = (m_press & {4{m_cfg[0]}}) | (m_rel & {4{m_cfg[1]}});
        clr = 4'h0;
        if (WrEn && Address == 2'd1) clr = WrData[3:0];
        if (IntAck && m_req) clr[m_id] = 1'b1;
        pend_n = (m_pend & ~clr) | evt;
        rq = m_pend & m_mask;
        req_n = (rq != 4'h0);
        id_n = m_id;
        for (int k = 3; k >= 0; k--) if (rq[k]) id_n = 2'(k);
        stab_n = m_stable; press_n = 4'h0; rel_n = 4'h0;
        for (int k = 0; k < 4; k++) begin
            h = {m_hist[k][6:0], m_p2[k]};
            m_hist[k] = h;
            if (!m_stable[k] && h == 8'hFF) begin stab_n[k] = 1'b1; press_n[k] = 1'b1; end
            if (m_stable[k] && h == 8'h00)  begin stab_n[k] = 1'b0; rel_n[k]   = 1'b1; end
        end
        m_p2 = m_p1;
        m_p1 = ~Keys;
        if (WrEn && Address == 2'd2) m_mask = WrData[3:0];
        if (WrEn && Address == 2'd3) m_cfg  = WrData[1:0];
        m_stable = stab_n; m_press = press_n; m_rel = rel_n;
        m_pend = pend_n; m_req = req_n; m_id = id_n; m_rd = rd_n;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge IO_Clock or negedge IO_Reset);
            if (!IO_Reset) m_reset();
            else           m_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge IO_Clock);
            chk("model_KeyState", {28'd0, KeyState}, {28'd0, m_stable});
            chk("model_IntReq",   {31'd0, IntReq},   {31'd0, m_req});
            chk("model_IntId",    {30'd0, IntId},    {30'd0, m_id});
            chk("model_RdData",   RdData,            m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge IO_Clock);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        WrEn = 1'b1; Address = a; WrData = d;
        step(1);
        WrEn = 1'b0; WrData = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        RdEn = 1'b1; Address = a;
        step(1);
        RdEn = 1'b0;
        d = RdData;
    endtask

    logic [31:0] rv;

    initial begin
        IO_Reset = 1'b0; Keys = 4'hF; RdEn = 1'b0; WrEn = 1'b0;
        Address = 2'd0; WrData = 32'd0; IntAck = 1'b0;
        step(3);

        // 1. reset values, idle keys
        chk("rst_KeyState", {28'd0, KeyState}, 32'd0);
        chk("rst_IntReq",   {31'd0, IntReq},   32'd0);
        chk("rst_IntId",    {30'd0, IntId},    32'd0);
        chk("rst_RdData",   RdData,            32'd0);
        IO_Reset = 1'b1;
        step(50);
        chk("idle_KeyState", {28'd0, KeyState}, 32'd0);
        chk("idle_IntReq",   {31'd0, IntReq},   32'd0);
        rd(2'd1, rv);  chk("idle_PENDING", rv, 32'd0);
        rd(2'd3, rv);  chk("rst_CONFIG",   rv, 32'd1);

        // 2. single press on key 0, latency pinned cycle by cycle
        wr(2'd2, 32'h1);
        Keys[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (i == 9)  chk("k0_before_10", {31'd0, KeyState[0]}, 32'd0);
            if (i == 10) chk("k0_at_10",     {31'd0, KeyState[0]}, 32'd1);
            if (i == 11) chk("k0_req_early", {31'd0, IntReq},      32'd0);
            if (i == 12) begin
                chk("k0_pending", RdData,            32'd1);
                chk("k0_req",     {31'd0, IntReq},   32'd1);
                chk("k0_id",      {30'd0, IntId},    32'd0);
            end
            if (i == 11) begin RdEn = 1'b1; Address = 2'd1; end
        end
        RdEn = 1'b0;
        rd(2'd0, rv);  chk("state_read", rv, 32'h1);
        IntAck = 1'b1; step(1); IntAck = 1'b0;
        step(2);
        chk("k0_req_cleared", {31'd0, IntReq}, 32'd0);

        // 3. bouncing key 1: one accepted press, 10 cycles after the last low edge
        Keys[1] = 1'b0; step(5);
        Keys[1] = 1'b1; step(1);
        Keys[1] = 1'b0; step(9);
        chk("k1_before_10", {31'd0, KeyState[1]}, 32'd0);
        step(1);
        chk("k1_at_10",     {31'd0, KeyState[1]}, 32'd1);
        step(2);
        rd(2'd1, rv);  chk("k1_pending", rv, 32'h2);
        chk("k1_masked_noreq", {31'd0, IntReq}, 32'd0);
        wr(2'd1, 32'h2);
        step(20);
        rd(2'd1, rv);  chk("k1_single_event", rv, 32'h0);

        // 4. simultaneous presses on keys 0 and 2, priority and handshake
        Keys = 4'hF; step(14);
        rd(2'd1, rv);  chk("release_disabled", rv, 32'h0);
        wr(2'd2, 32'hF);
        rd(2'd2, rv);  chk("mask_read", rv, 32'hF);
        Keys = 4'b1010; step(12);
        chk("dual_req", {31'd0, IntReq}, 32'd1);
        chk("dual_id0", {30'd0, IntId},  32'd0);
        IntAck = 1'b1; step(1); IntAck = 1'b0;
        RdEn = 1'b1; Address = 2'd1; step(1); RdEn = 1'b0;
        chk("dual_pending_after_ack", RdData, 32'h4);
        chk("dual_req_again",         {31'd0, IntReq}, 32'd1);
        chk("dual_id2",               {30'd0, IntId},  32'd2);
        IntAck = 1'b1; step(1); IntAck = 1'b0;
        step(1);
        chk("dual_req_done", {31'd0, IntReq}, 32'd0);
        chk("dual_id_held",  {30'd0, IntId},  32'd2);
        IntAck = 1'b1; step(1); IntAck = 1'b0;   // ignored: no request
        step(1);
        chk("stray_ack", {31'd0, IntReq}, 32'd0);

        // 5. release-only events on key 3, set wins over same-cycle W1C
        Keys = 4'hF; step(14);
        wr(2'd3, 32'h2);
        Keys[3] = 1'b0; step(14);
        rd(2'd1, rv);  chk("k3_press_no_event", rv, 32'h0);
        Keys[3] = 1'b1; step(12);
        rd(2'd1, rv);  chk("k3_release_event", rv, 32'h8);
        chk("k3_req", {31'd0, IntReq}, 32'd1);
        chk("k3_id",  {30'd0, IntId},  32'd3);
        Keys[3] = 1'b0; step(14);
        Keys[3] = 1'b1; step(10);
        wr(2'd1, 32'h8);
        rd(2'd1, rv);  chk("set_wins", rv, 32'h8);
        wr(2'd1, 32'h8);
        rd(2'd1, rv);  chk("w1c_clears", rv, 32'h0);
        wr(2'd0, 32'hF);
        rd(2'd0, rv);  chk("state_ro", rv, 32'h0);

        // 6. reset mid-debounce with pending 0101
        wr(2'd3, 32'h1);
        Keys = 4'b1010; step(12);
        rd(2'd1, rv);  chk("pre_rst_pending", rv, 32'h5);
        Keys = 4'b1000; step(5);
        IO_Reset = 1'b0;
        #1;
        chk("async_KeyState", {28'd0, KeyState}, 32'd0);
        chk("async_IntReq",   {31'd0, IntReq},   32'd0);
        chk("async_IntId",    {30'd0, IntId},    32'd0);
        chk("async_RdData",   RdData,            32'd0);
        Keys = 4'hF;
        step(3);
        IO_Reset = 1'b1;
        step(30);
        chk("post_rst_req", {31'd0, IntReq}, 32'd0);
        rd(2'd1, rv);  chk("post_rst_pending", rv, 32'h0);
        rd(2'd2, rv);  chk("post_rst_mask",    rv, 32'h0);
        rd(2'd3, rv);  chk("post_rst_config",  rv, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
